// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package add_seq_pkg;

    localparam int unsigned WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word index width: max(1, clog2(words)).
    function automatic int unsigned idx_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/add_word.sv
// Combinational single-word adder shared by every word of a sequenced add.
module add_word
    import add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);

    logic [WORD_W:0] full_c;

    // Full add with carry-in; top bit is the carry out.
    always_comb begin
        full_c = (WORD_W+1)'(a_i) + (WORD_W+1)'(b_i) + (WORD_W+1)'(cin_i);
    end

    assign sum_o  = full_c[WORD_W-1:0];
    assign cout_o = full_c[WORD_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add sequencer: WORDS x 64-bit operands summed one word per
// cycle, LS word first, through a single shared add_word instance.
// Optional macro ADD_SEQ_SUB_EN adds an in_sub port (A - B via ~B + 1).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_a,
    input  logic [WORDS*WORD_W-1:0] in_b,
    input  logic                    in_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                    in_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef logic [WORDS-1:0][WORD_W-1:0] wide_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    wide_t            a_q, a_d;
    wide_t            b_q, b_d;
    wide_t            sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    wide_t            b_cap_c;
    logic             cin_cap_c;
    logic [WORD_W-1:0] word_sum_c;
    logic             word_cout_c;

    // Operand B and carry as they will be captured (inverted for subtract).
    always_comb begin
        b_cap_c   = wide_t'(in_b);
        cin_cap_c = in_cin;
`ifdef ADD_SEQ_SUB_EN
        if (in_sub) begin
            b_cap_c   = ~wide_t'(in_b);
            cin_cap_c = 1'b1;
        end
`endif
    end

    add_word u_add_word (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .sum_o  (word_sum_c),
        .cout_o (word_cout_c)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = wide_t'(in_a);
                    b_d        = b_cap_c;
                    carry_d    = cin_cap_c;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                sum_d[idx_q] = word_sum_c;
                carry_d      = word_cout_c;
                if (idx_q == LAST_IDX) begin
                    cout_d      = word_cout_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl at WORDS = 4, 2 and 1.
module tb_add_seq_ctrl;

    logic         clk;
    logic         reset;
    logic [255:0] a_drv, b_drv;
    logic         cin_drv;
    logic         sub_drv;
    logic [2:0]   in_valid_v, out_ready_v;
    logic [2:0]   in_ready_w, out_valid_w, busy_w, cout_w;
    logic [255:0] sum4;
    logic [127:0] sum2;
    logic [63:0]  sum1;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    add_seq_ctrl #(.WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .in_a(a_drv), .in_b(b_drv), .in_cin(cin_drv),
`ifdef ADD_SEQ_SUB_EN
        .in_sub(sub_drv),
`endif
        .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
        .out_sum(sum4), .out_cout(cout_w[0]), .busy(busy_w[0])
    );

    add_seq_ctrl #(.WORDS(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .in_a(a_drv[127:0]), .in_b(b_drv[127:0]), .in_cin(cin_drv),
`ifdef ADD_SEQ_SUB_EN
        .in_sub(sub_drv),
`endif
        .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
        .out_sum(sum2), .out_cout(cout_w[1]), .busy(busy_w[1])
    );

    add_seq_ctrl #(.WORDS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .in_a(a_drv[63:0]), .in_b(b_drv[63:0]), .in_cin(cin_drv),
`ifdef ADD_SEQ_SUB_EN
        .in_sub(sub_drv),
`endif
        .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
        .out_sum(sum1), .out_cout(cout_w[2]), .busy(busy_w[2])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nwords(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 2 : 1);
    endfunction

    function automatic logic [255:0] get_sum(input int sel);
        case (sel)
            0:       return sum4;
            1:       return 256'(sum2);
            default: return 256'(sum1);
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: {cout, sum} = A + B + cin modulo 2^(64*nw); subtract is A + ~B + 1.
    function automatic logic [256:0] model(input int nw, input logic [255:0] a,
                                           input logic [255:0] b, input logic cin,
                                           input logic sub);
        logic [256:0] mask, bb, full;
        logic         c;
        int           w;
        w    = 64 * nw;
        mask = (257'(1) << w) - 257'(1);
        bb   = sub ? ~{1'b0, b} : {1'b0, b};
        c    = sub ? 1'b1 : cin;
        full = ({1'b0, a} & mask) + (bb & mask) + 257'(c);
        return {full[w], full[255:0] & mask[255:0]};
    endfunction

    // Issue one operation and wait until the result is presented (left in DONE).
    task automatic do_op(input int sel, input logic [255:0] a, input logic [255:0] b,
                         input logic cin, input logic sub, input string tag);
        logic [256:0] exp;
        int           nw;
        int           lat;
        nw  = nwords(sel);
        exp = model(nw, a, b, cin, sub);
        @(negedge clk);
        check({tag, ".in_ready"}, 256'(in_ready_w[sel]), 256'(1));
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub;
        in_valid_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[sel] = 1'b0;
        a_drv = rand256(); b_drv = rand256(); cin_drv = 1'($urandom); sub_drv = 1'($urandom);
        check({tag, ".busy"}, 256'(busy_w[sel]), 256'(1));
        lat = 0;
        while (!out_valid_w[sel] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 256'(lat), 256'(nw));
        check({tag, ".sum"}, get_sum(sel), exp[255:0]);
        check({tag, ".cout"}, 256'(cout_w[sel]), 256'(exp[256]));
    endtask

    // Accept the result and confirm return to IDLE on the next edge.
    task automatic release_op(input int sel, input string tag);
        out_ready_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_v[sel] = 1'b0;
        check({tag, ".rel_valid"}, 256'(out_valid_w[sel]), 256'(0));
        check({tag, ".rel_ready"}, 256'(in_ready_w[sel]), 256'(1));
        check({tag, ".rel_busy"}, 256'(busy_w[sel]), 256'(0));
    endtask

    initial begin
        logic [256:0] exp;
        logic [255:0] ra, rb;
        logic         rsub;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        a_drv       = '0;
        b_drv       = '0;
        cin_drv     = 1'b0;
        sub_drv     = 1'b0;
        in_valid_v  = '0;
        out_ready_v = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.valid", 256'(out_valid_w), 256'(0));
        check("rst.busy", 256'(busy_w), 256'(0));
        check("rst.sum4", sum4, 256'(0));
        check("rst.cout", 256'(cout_w), 256'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 256'(in_ready_w), 256'(3'b111));

        // Directed cases
        do_op(1, 256'({128{1'b1}}), 256'(1), 1'b0, 1'b0, "w2_wrap");
        release_op(1, "w2_wrap");
        do_op(0, 256'(1) << 64, 256'(64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 1'b0, "w4_carry");
        check("w4_carry.exact", sum4, 256'(2) << 64);
        release_op(0, "w4_carry");
        do_op(2, 256'(64'hFFFF_FFFF_FFFF_FFFF), 256'(0), 1'b1, 1'b0, "w1_corner");
        release_op(2, "w1_corner");

        // Backpressure: result held, in_ready low, pulsed in_valid ignored
        ra  = rand256();
        rb  = rand256();
        exp = model(4, ra, rb, 1'b1, 1'b0);
        do_op(0, ra, rb, 1'b1, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid_v[0] = (i == 4);
            check("bp.sum", sum4, exp[255:0]);
            check("bp.valid", 256'(out_valid_w[0]), 256'(1));
            check("bp.in_ready", 256'(in_ready_w[0]), 256'(0));
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        release_op(0, "bp");
        do_op(0, 256'(123), 256'(456), 1'b0, 1'b0, "bp_next");
        release_op(0, "bp_next");

        // Reset mid-RUN after two words
        @(negedge clk);
        a_drv = rand256(); b_drv = rand256(); in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid.valid", 256'(out_valid_w[0]), 256'(0));
        check("mid.busy", 256'(busy_w[0]), 256'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid.in_ready", 256'(in_ready_w[0]), 256'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid.no_result", 256'(out_valid_w[0]), 256'(0));
        end
        do_op(0, 256'(5), 256'(7), 1'b0, 1'b0, "mid_fresh");
        check("mid_fresh.twelve", sum4, 256'(12));
        release_op(0, "mid_fresh");

`ifdef ADD_SEQ_SUB_EN
        do_op(1, 256'(3), 256'(5), 1'b0, 1'b1, "sub_neg");
        check("sub_neg.exact", 256'(sum2), 256'({128{1'b1}}) - 256'(1));
        release_op(1, "sub_neg");
        do_op(1, 256'(5), 256'(3), 1'b0, 1'b1, "sub_pos");
        check("sub_pos.exact", 256'(sum2), 256'(2));
        release_op(1, "sub_pos");
`endif

        // Randomized operations on each width
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 15; k++) begin
                ra = rand256();
                rb = rand256();
                if (k % 5 == 0) ra = '1;
`ifdef ADD_SEQ_SUB_EN
                rsub = 1'($urandom);
`else
                rsub = 1'b0;
`endif
                do_op(s, ra, rb, 1'($urandom), rsub, "rnd");
                release_op(s, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
